p2a_loader: RTL and testbench

- Writer side of the DDFS phase-to-amplitude (p2a) RAM write port. Drives p2a_we, p2a_waddr and p2a_din to fill all 256 Q1.15 table entries.
- Fills the table in one of two ways: from one of three built-in waveforms (sawtooth, triangle, square), or from a byte stream supplied by a UART-style receiver.
- Sits between the control logic / UART receiver and the synthesizer's p2a write port. Lets the waveform be swapped at run time without reconfiguring the device.

---
 rtl/p2a_pkg.sv | 28 ++
 rtl/p2a_if.sv | 16 +
 rtl/p2a_wave_gen.sv | 34 +++
 rtl/p2a_loader.sv | 163 ++++++++++++++++
 tb/tb_p2a_loader.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/p2a_pkg.sv
// p2a_pkg: shared definitions for the DDFS phase-to-amplitude table loader.
//   - table geometry (P2A_AW address bits, P2A_DW data bits)
//   - wave_sel source encodings
//   - Q1.15 reference constants
//   - loader state enum (also exported on the loader's debug port)
package p2a_pkg;

  localparam int P2A_AW = 8;
  localparam int P2A_DW = 16;

  localparam logic [1:0] WAVE_SAW    = 2'd0;
  localparam logic [1:0] WAVE_TRI    = 2'd1;
  localparam logic [1:0] WAVE_SQR    = 2'd2;
  localparam logic [1:0] WAVE_STREAM = 2'd3;

  localparam logic [15:0] Q15_MAX     = 16'h7FFF;
  localparam logic [15:0] Q15_MIN_SYM = 16'h8001;
  localparam logic [15:0] Q15_NEG1    = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_RX_LO = 3'd2,
    ST_RX_HI = 3'd3,
    ST_DONE  = 3'd4
  } p2a_state_e;

endpackage

// File: rtl/p2a_if.sv
// p2a_if: write port of the phase-to-amplitude RAM.
//   we    : write enable, one entry written per cycle it is high
//   waddr : table address
//   din   : Q1.15 sample
// master = table writer (p2a_loader), slave = RAM.
interface p2a_if #(
  parameter int AW = 8,
  parameter int DW = 16
) ();
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] din;

  modport master (output we, output waddr, output din);
  modport slave  (input  we, input  waddr, input  din);
endinterface

// File: rtl/p2a_wave_gen.sv
// p2a_wave_gen: combinational built-in waveform sample for one table address.
//   addr_i     : table address (phase)
//   wave_sel_i : WAVE_SAW / WAVE_TRI / WAVE_SQR (stream code yields -1.0)
//   sample_o   : Q1.15 sample
module p2a_wave_gen
  import p2a_pkg::*;
#(
  parameter int AW = P2A_AW,
  parameter int DW = P2A_DW
) (
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    wave_sel_i,
  output logic [DW-1:0] sample_o
);

  localparam logic [DW-1:0] S_NEG1    = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] S_MAX     = ~S_NEG1;
  localparam logic [DW-1:0] S_MIN_SYM = S_NEG1 | {{(DW-1){1'b0}}, 1'b1};

  logic [AW-2:0] tri_j;

  always_comb begin
    // Fold the upper half back down so the ramp descends symmetrically.
    tri_j = addr_i[AW-1] ? ~addr_i[AW-2:0] : addr_i[AW-2:0];
    // Offset binary -> two's complement by flipping the sign bit.
    case (wave_sel_i)
      WAVE_SAW: sample_o = {addr_i, {(DW-AW){1'b0}}} ^ S_NEG1;
      WAVE_TRI: sample_o = {tri_j, {(DW-AW+1){1'b0}}} ^ S_NEG1;
      WAVE_SQR: sample_o = addr_i[AW-1] ? S_MIN_SYM : S_MAX;
      default:  sample_o = S_NEG1;
    endcase
  end

endmodule

// File: rtl/p2a_loader.sv
// p2a_loader: fills all 2**AW entries of the p2a RAM, either from a built-in
// waveform (one write per cycle) or from a little-endian byte stream.
//   clk, reset : clock, asynchronous active-high reset
//   start      : one-cycle load request, honoured only in IDLE
//   wave_sel   : source latched at start (saw/tri/square/stream)
//   abort      : ends a load in progress, no done_tick
//   rx_valid   : rx_data qualifier
//   rx_data    : stream byte, low byte of each word first
//   p2a        : RAM write port (master)
//   busy       : load in progress
//   done_tick  : one-cycle pulse after the last entry was written
//   dbg_state  : current FSM state
//
// Handshake: rx_valid is a pure one-cycle strobe with no back-pressure; each
// cycle rx_valid is high carries exactly one byte, and a byte arriving in a
// state that does not expect one is dropped.
module p2a_loader
  import p2a_pkg::*;
#(
  parameter int AW = P2A_AW,
  parameter int DW = P2A_DW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   wave_sel,
  input  logic         abort,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  p2a_if.master        p2a,
  output logic         busy,
  output logic         done_tick,
  output p2a_state_e   dbg_state
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  p2a_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [7:0]    lo_q, lo_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] din_q, din_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [AW-1:0] gen_addr;
  logic [1:0]    gen_sel;
  logic [DW-1:0] gen_sample;

  // Entry 0 is issued directly from IDLE so it lands in the cycle after start;
  // GEN then continues from address 1.
  assign gen_addr = (state_q == ST_IDLE) ? '0 : cnt_q;
  assign gen_sel  = (state_q == ST_IDLE) ? wave_sel : sel_q;

  p2a_wave_gen #(.AW(AW), .DW(DW)) u_wave_gen (
    .addr_i     (gen_addr),
    .wave_sel_i (gen_sel),
    .sample_o   (gen_sample)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          sel_d = wave_sel;
          cnt_d = '0;
          if (wave_sel == WAVE_STREAM) begin
            state_d = ST_RX_LO;
          end else begin
            we_d    = 1'b1;
            waddr_d = '0;
            din_d   = gen_sample;
            cnt_d   = {{(AW-1){1'b0}}, 1'b1};
            state_d = ST_GEN;
          end
        end
      end
      ST_GEN: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        din_d   = gen_sample;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_DONE;
      end
      ST_RX_LO: begin
        if (rx_valid) begin
          lo_d    = rx_data;
          state_d = ST_RX_HI;
        end
      end
      ST_RX_HI: begin
        if (rx_valid) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          din_d   = DW'({rx_data, lo_q});
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LAST_ADDR) ? ST_DONE : ST_RX_LO;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any write or completion scheduled this cycle and
    // discards a half-received word.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      din_d   = din_q;
      done_d  = 1'b0;
      lo_d    = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign p2a.we    = we_q;
  assign p2a.waddr = waddr_q;
  assign p2a.din   = din_q;
  assign busy      = busy_q;
  assign done_tick = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_p2a_loader.sv
// tb_p2a_loader: self-checking bench for p2a_loader.
module tb_p2a_loader;
  import p2a_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start = 1'b0;
  logic [1:0] wave_sel = 2'd0;
  logic       abort = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       busy;
  logic       done_tick;
  p2a_state_e dbg_state;

  always #5 clk = ~clk;

  p2a_if #(.AW(8), .DW(16)) p2a_bus ();

  p2a_loader #(.AW(8), .DW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .wave_sel  (wave_sel),
    .abort     (abort),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .p2a       (p2a_bus),
    .busy      (busy),
    .done_tick (done_tick),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          we_count = 0;
  int          done_count = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_e;
  logic [15:0] mem [256];

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  addr;
    logic [15:0] dout;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference waveforms in signed arithmetic.
  function automatic logic [15:0] wave_ref(input int i, input int sel);
    int v;
    case (sel)
      0:       v = i * 256 - 32768;
      1:       v = ((i < 128) ? i : 255 - i) * 512 - 32768;
      default: v = (i < 128) ? 32767 : -32767;
    endcase
    return v[15:0];
  endfunction

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (p2a_bus.we === 1'b1) begin
      we_count++;
      mem[p2a_bus.waddr] = p2a_bus.din;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 p2a_bus.waddr, p2a_bus.din);
      end else begin
        exp_e = exp_q.pop_front();
        check("write", {8'd0, p2a_bus.waddr, p2a_bus.din}, {8'd0, exp_e});
      end
    end
    if (done_tick === 1'b1) done_count++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    foreach (mem[k]) mem[k] = 'x;
  endtask

  task automatic vec_check(input logic [1:0] sel);
    foreach (vecs[k]) begin
      if (vecs[k].sel == sel)
        check($sformatf("vec_sel%0d_addr%0d", sel, vecs[k].addr), mem[vecs[k].addr], vecs[k].dout);
    end
  endtask

  task automatic run_gen(input logic [1:0] sel, input bit noise);
    int we0, d0;
    clear_mem();
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), wave_ref(i, int'(sel))});
    @(posedge clk); #1;
    start = 1'b1; wave_sel = sel;
    @(posedge clk); #1;
    start = 1'b0; wave_sel = 2'($urandom_range(0, 3));
    we0 = we_count; d0 = done_count;
    for (int c = 1; c <= 257; c++) begin
      @(negedge clk);
      check("gen_busy", busy, (c <= 256));
      check("gen_we", p2a_bus.we, (c <= 256));
      check("gen_done", done_tick, (c == 257));
      @(posedge clk); #1;
      if (noise && (c + 1 <= 256)) begin
        start    = ($urandom_range(0, 3) == 0);
        rx_valid = ($urandom_range(0, 3) == 0);
        rx_data  = 8'($urandom);
      end else begin
        start    = 1'b0;
        rx_valid = 1'b0;
      end
    end
    check("gen_we_pulses", we_count - we0, 256);
    check("gen_done_count", done_count - d0, 1);
    check("gen_q_empty", exp_q.size(), 0);
    vec_check(sel);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic start_stream();
    @(posedge clk); #1;
    start = 1'b1; wave_sel = WAVE_STREAM;
    @(posedge clk); #1;
    start = 1'b0; wave_sel = 2'($urandom_range(0, 3));
  endtask

  task automatic run_stream(input int max_gap);
    logic [15:0] w;
    int d0;
    clear_mem();
    d0 = done_count;
    start_stream();
    @(negedge clk);
    check("stream_busy", busy, 1);
    check("stream_we_idle", p2a_bus.we, 0);
    for (int i = 0; i < 256; i++) begin
      if (i == 0)      w = 16'h1234;
      else if (i == 1) w = 16'hABCD;
      else             w = 16'($urandom);
      exp_q.push_back({8'(i), w});
      send_byte(w[7:0], $urandom_range(0, max_gap));
      @(negedge clk);
      check("stream_lo_no_we", p2a_bus.we, 0);
      send_byte(w[15:8], $urandom_range(0, max_gap));
      @(negedge clk);
      check("stream_hi_we", p2a_bus.we, 1);
      check("stream_done_early", done_tick, 0);
    end
    @(negedge clk);
    check("stream_done_tick", done_tick, 1);
    check("stream_busy_low", busy, 0);
    @(posedge clk); #1;
    check("stream_done_count", done_count - d0, 1);
    check("stream_q_empty", exp_q.size(), 0);
    vec_check(WAVE_STREAM);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    int sel;
    bit found;

    vecs.push_back('{WAVE_SAW, 8'd0,   16'h8000});
    vecs.push_back('{WAVE_SAW, 8'd128, 16'h0000});
    vecs.push_back('{WAVE_SAW, 8'd255, 16'h7F00});
    vecs.push_back('{WAVE_TRI, 8'd0,   16'h8000});
    vecs.push_back('{WAVE_TRI, 8'd127, 16'h7E00});
    vecs.push_back('{WAVE_TRI, 8'd128, 16'h7E00});
    vecs.push_back('{WAVE_TRI, 8'd255, 16'h8000});
    vecs.push_back('{WAVE_SQR, 8'd0,   Q15_MAX});
    vecs.push_back('{WAVE_SQR, 8'd127, Q15_MAX});
    vecs.push_back('{WAVE_SQR, 8'd128, Q15_MIN_SYM});
    vecs.push_back('{WAVE_SQR, 8'd255, Q15_MIN_SYM});
    vecs.push_back('{WAVE_STREAM, 8'd0, 16'h1234});
    vecs.push_back('{WAVE_STREAM, 8'd1, 16'hABCD});

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", p2a_bus.we, 0);
    check("rst_waddr", p2a_bus.waddr, 0);
    check("rst_din", p2a_bus.din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_tick, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;

    run_gen(WAVE_SAW, 1'b0);
    run_gen(WAVE_TRI, 1'b1);   // stray start / rx_valid during the load
    run_gen(WAVE_SQR, 1'b0);

    // start and abort together in IDLE, plus stray bytes: nothing happens
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; wave_sel = WAVE_SAW;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h99;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_we", p2a_bus.we, 0);
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end

    run_stream(20);

    // abort after three stream bytes
    clear_mem();
    d0 = done_count;
    exp_q.push_back({8'd0, 16'h5A3C});
    start_stream();
    send_byte(8'h3C, 2);
    @(negedge clk);
    send_byte(8'h5A, 2);
    @(negedge clk);
    check("abort_first_we", p2a_bus.we, 1);
    send_byte(8'h77, 2);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_we", p2a_bus.we, 0);
    check("abort_done", done_tick, 0);
    check("abort_state", dbg_state, ST_IDLE);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", done_tick, 0);
    end
    @(posedge clk); #1;
    check("abort_done_count", done_count - d0, 0);
    check("abort_q_empty", exp_q.size(), 0);
    run_gen(WAVE_SAW, 1'b0);

    // abort in the same cycle as a high byte: the write is suppressed
    start_stream();
    send_byte(8'h11, 1);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h22; abort = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_hi_we", p2a_bus.we, 0);
    check("abort_hi_busy", busy, 0);
    @(posedge clk); #1;

    // reset while GEN is writing address 100
    clear_mem();
    for (int i = 0; i <= 100; i++) exp_q.push_back({8'(i), wave_ref(i, 1)});
    @(posedge clk); #1;
    start = 1'b1; wave_sel = WAVE_TRI;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (p2a_bus.we === 1'b1 && p2a_bus.waddr === 8'd100) found = 1'b1;
    end
    check("reset_wait_addr100", found, 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_we", p2a_bus.we, 0);
    check("midrst_waddr", p2a_bus.waddr, 0);
    check("midrst_din", p2a_bus.din, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done_tick, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_q_empty", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    run_gen(WAVE_SQR, 1'b0);

    // randomized loads against the reference model
    for (int k = 0; k < 4; k++) begin
      sel = $urandom_range(0, 3);
      if (sel == 3) run_stream(3);
      else          run_gen(2'(sel), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
